// File: rtl/count_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : count_seq_pkg
//  Description : Shared types and default sizes for the count_sequencer
//                block (state encoding, count and divider widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package count_seq_pkg;

    // Controller states; encodings are fixed so debug taps read consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // 8-bit count, 26-bit divider: 50 MHz board clock down to roughly 1 Hz.
    localparam int c_default_width     = 8;
    localparam int c_default_div_width = 26;

endpackage
`default_nettype wire

// File: rtl/count_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer_if
//  Description : Command/status bundle between the user-input side (master)
//                and the count_sequencer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface count_sequencer_if
    import count_seq_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int DIV_WIDTH = c_default_div_width
);

    logic                 start;
    logic                 stop;
    logic                 clear;
    logic [DIV_WIDTH-1:0] rate;
    logic [WIDTH-1:0]     target;
    logic [WIDTH-1:0]     count;
    logic                 tick;
    logic                 running;
    logic                 done;

    modport master (
        output start, stop, clear, rate, target,
        input  count, tick, running, done
    );

    modport slave (
        input  start, stop, clear, rate, target,
        output count, tick, running, done
    );

endinterface
`default_nettype wire

// File: rtl/count_sequencer_rate_divider.sv
`default_nettype none
// ============================================================================
//  Module      : rate_divider
//  Description : Loadable down-counter that emits a registered one-cycle
//                expire pulse each time it passes through zero and reloads.
//                Priority: clear > load > hold > count.
//  Revision    : 1.0 - initial release
// ============================================================================
module rate_divider #(
    parameter int DIV_WIDTH = 26
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_clear,
    input  logic                 i_load,
    input  logic                 i_hold,
    input  logic [DIV_WIDTH-1:0] i_reload,
    output logic                 o_expire,
    output logic [DIV_WIDTH-1:0] o_count
);

    localparam logic [DIV_WIDTH-1:0] c_one = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_count;
    logic                 r_expire;

    // Down-count with reload on zero; expire marks the edge where zero was seen.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_expire <= 1'b0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_expire <= 1'b0;
        end else if (i_load) begin
            r_count  <= i_reload;
            r_expire <= 1'b0;
        end else if (i_hold) begin
            r_expire <= 1'b0;
        end else if (r_count == '0) begin
            r_count  <= i_reload;
            r_expire <= 1'b1;
        end else begin
            r_count  <= r_count - c_one;
            r_expire <= 1'b0;
        end
    end

    assign o_expire = r_expire;
    assign o_count  = r_count;

endmodule
`default_nettype wire

// File: rtl/count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : count_sequencer
//  Description : Run/pause/clear controller for the 8-bit counter. Latches a
//                rate and target on start, divides the clock down to a
//                one-cycle tick and holds the count register.
//                Build option COUNT_SEQ_WRAP_EN: free-running wrap mode
//                (count returns to 0 after target, done pulses). Undefined:
//                one-shot mode (stop in DONE at target, done is a level).
//  Revision    : 1.0 - initial release
// ============================================================================
module count_sequencer
    import count_seq_pkg::*;
#(
    parameter int WIDTH     = c_default_width,
    parameter int DIV_WIDTH = c_default_div_width
) (
    input  logic             clock,
    input  logic             reset,
    count_sequencer_if.slave bus
);

    localparam logic [DIV_WIDTH-1:0] c_div_one   = DIV_WIDTH'(1);
    localparam logic [WIDTH-1:0]     c_count_one = WIDTH'(1);

    state_t               r_state;
    logic [WIDTH-1:0]     r_count;
    logic [WIDTH-1:0]     r_target_q;
    logic [DIV_WIDTH-1:0] r_rate_q;
    logic                 r_running;
    logic                 r_done;

    logic                 w_latch;
    logic                 w_advance;
    logic                 w_step;
    logic                 w_hit;
    logic                 w_tick;
    logic [DIV_WIDTH-1:0] w_rate_eff;
    logic [DIV_WIDTH-1:0] w_reload;
    logic [DIV_WIDTH-1:0] w_div_count;
    logic [WIDTH-1:0]     w_count_inc;
    logic [WIDTH-1:0]     w_count_tick;

    // Command decode: clear beats stop beats start; start only latches from IDLE/DONE.
    always_comb begin
        w_latch    = 1'b0;
        w_advance  = 1'b0;
        w_rate_eff = (bus.rate == '0) ? c_div_one : bus.rate;
        if (!bus.clear && !bus.stop) begin
            w_latch   = bus.start && ((r_state == IDLE) || (r_state == DONE));
            w_advance = (r_state == RUN);
        end
        w_reload = w_latch ? (w_rate_eff - c_div_one) : (r_rate_q - c_div_one);
        w_step   = w_advance && (w_div_count == '0);
    end

    // Next count on a tick, and whether that new value reaches the target.
    always_comb begin
        w_count_inc = r_count + c_count_one;
`ifdef COUNT_SEQ_WRAP_EN
        w_count_tick = (r_count == r_target_q) ? '0 : w_count_inc;
`else
        w_count_tick = w_count_inc;
`endif
        w_hit = (w_count_tick == r_target_q);
    end

    rate_divider #(
        .DIV_WIDTH (DIV_WIDTH)
    ) u_rate_divider (
        .clock    (clock),
        .reset    (reset),
        .i_clear  (bus.clear),
        .i_load   (w_latch),
        .i_hold   (!w_advance),
        .i_reload (w_reload),
        .o_expire (w_tick),
        .o_count  (w_div_count)
    );

    // Controller FSM with registered count, running and done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_rate_q   <= '0;
            r_target_q <= '0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
`ifdef COUNT_SEQ_WRAP_EN
            // done is a pulse in wrap mode; only a target hit re-asserts it.
            r_done <= 1'b0;
`endif
            if (bus.clear) begin
                r_state   <= IDLE;
                r_count   <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else if (bus.stop) begin
                // Only RUN reacts; divider and count simply hold.
                if (r_state == RUN) begin
                    r_state   <= PAUSE;
                    r_running <= 1'b0;
                end
            end else begin
                case (r_state)
                    IDLE, DONE: begin
                        if (bus.start) begin
                            r_state    <= RUN;
                            r_running  <= 1'b1;
                            r_count    <= '0;
                            r_rate_q   <= w_rate_eff;
                            r_target_q <= bus.target;
                            r_done     <= 1'b0;
                        end
                    end
                    RUN: begin
                        if (w_step) begin
                            r_count <= w_count_tick;
`ifdef COUNT_SEQ_WRAP_EN
                            if (w_hit) begin
                                r_done <= 1'b1;
                            end
`else
                            if (w_hit) begin
                                r_state   <= DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end
`endif
                        end
                    end
                    PAUSE: begin
                        // Resume keeps the held divider phase and latched rate/target.
                        if (bus.start) begin
                            r_state   <= RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.count   = r_count;
    assign bus.tick    = w_tick;
    assign bus.running = r_running;
    assign bus.done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_count_sequencer
//  Description : Self-checking bench for count_sequencer against a cycle-level
//                behavioural model ("edges left until next tick" formulation).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_count_sequencer;

    localparam int WIDTH     = 8;
    localparam int DIV_WIDTH = 26;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    count_sequencer_if #(.WIDTH(WIDTH), .DIV_WIDTH(DIV_WIDTH)) bus ();

    count_sequencer #(
        .WIDTH     (WIDTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state.
    int         m_mode;
    logic [7:0] m_count;
    logic [7:0] m_target;
    int         m_rate;
    int         m_left;
    logic       m_tick;
    logic       m_done;

    function automatic logic [10:0] model_vec();
        return {m_count, m_tick, (m_mode == M_RUN), m_done};
    endfunction

    function automatic logic [10:0] dut_vec();
        return {bus.count, bus.tick, bus.running, bus.done};
    endfunction

    task automatic model_reset();
        m_mode   = M_IDLE;
        m_count  = 8'd0;
        m_target = 8'd0;
        m_rate   = 0;
        m_left   = 0;
        m_tick   = 1'b0;
        m_done   = 1'b0;
    endtask

    // One clock edge of the behavioural rules, using the inputs held at the edge.
    task automatic model_edge();
        m_tick = 1'b0;
`ifdef COUNT_SEQ_WRAP_EN
        m_done = 1'b0;
`endif
        if (reset) begin
            model_reset();
        end else if (bus.clear) begin
            m_mode  = M_IDLE;
            m_count = 8'd0;
            m_done  = 1'b0;
        end else if (bus.stop) begin
            if (m_mode == M_RUN) m_mode = M_PAUSE;
        end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
            if (bus.start) begin
                m_mode   = M_RUN;
                m_count  = 8'd0;
                m_rate   = (bus.rate == 0) ? 1 : int'(bus.rate);
                m_target = bus.target;
                m_left   = m_rate;
                m_done   = 1'b0;
            end
        end else if (m_mode == M_RUN) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_left = m_rate;
                m_tick = 1'b1;
`ifdef COUNT_SEQ_WRAP_EN
                m_count = (m_count == m_target) ? 8'd0 : m_count + 8'd1;
                m_done  = (m_count == m_target);
`else
                m_count = m_count + 8'd1;
                if (m_count == m_target) begin
                    m_mode = M_DONE;
                    m_done = 1'b1;
                end
`endif
            end
        end else if (bus.start) begin
            m_mode = M_RUN;
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_cmd(input logic s, input logic p, input logic c);
        bus.start = s;
        bus.stop  = p;
        bus.clear = c;
    endtask

    task automatic do_start(input int r, input int t);
        bus.rate   = DIV_WIDTH'(r);
        bus.target = WIDTH'(t);
        set_cmd(1'b1, 1'b0, 1'b0);
        step();
        set_cmd(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_clear();
        set_cmd(1'b0, 1'b0, 1'b1);
        step();
        set_cmd(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_cmd(1'b0, 1'b0, 1'b0);
        bus.rate   = '0;
        bus.target = '0;
        model_reset();
        step();
        step();
        n_cmp++;
        if (dut_vec() !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec(), 11'd0);
        end
        reset = 1'b0;
        do_start(1, 0);
        for (int i = 0; i < 5; i++) step();
        n_cmp++;
        if (bus.count !== 8'd5 || bus.running !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_precount: got count %0d run %b expected 5 1", bus.count, bus.running);
        end
        // Assert reset between edges: outputs must clear without a clock edge.
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_cmp++;
        if (dut_vec() !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected %h", dut_vec(), 11'd0);
        end
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec() || bus.running !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_oneshot_basic();
        do_clear();
        do_start(3, 4);
        for (int k = 1; k <= 16; k++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL basic_model k=%0d: got %h expected %h", k, dut_vec(), model_vec());
            end
`ifndef COUNT_SEQ_WRAP_EN
            if (k % 3 == 0 && k <= 12) begin
                n_cmp++;
                if (bus.tick !== 1'b1 || bus.count !== 8'(k / 3)) begin
                    n_fail++;
                    $display("FAIL basic_step k=%0d: got count %0d tick %b expected %0d 1", k, bus.count, bus.tick, k / 3);
                end
            end
            if (k >= 12) begin
                n_cmp++;
                if (bus.done !== 1'b1 || bus.running !== 1'b0 || bus.count !== 8'd4 || (k > 12 && bus.tick !== 1'b0)) begin
                    n_fail++;
                    $display("FAIL basic_done k=%0d: got %h expected count 4 done 1 run 0", k, dut_vec());
                end
            end
`endif
        end
    endtask

    task automatic test_pause();
        logic [7:0] held;
        do_clear();
        do_start(2, 10);
        for (int i = 0; i < 40 && bus.count !== 8'd3; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL pause_run: got %h expected %h", dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (bus.count !== 8'd3) begin
            n_fail++;
            $display("FAIL pause_reach: got count %0d expected 3 within bound", bus.count);
        end
        held = bus.count;
        set_cmd(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            n_cmp++;
            if (bus.count !== held || bus.running !== 1'b0 || bus.tick !== 1'b0 || dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL pause_hold: got %h expected count %0d frozen", dut_vec(), held);
            end
        end
        set_cmd(1'b1, 1'b0, 1'b0);
        step();
        set_cmd(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL pause_resume: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_all_commands();
        do_clear();
        do_start(2, 50);
        for (int i = 0; i < 40 && bus.count !== 8'd7; i++) step();
        n_cmp++;
        if (bus.count !== 8'd7) begin
            n_fail++;
            $display("FAIL allcmd_reach: got count %0d expected 7 within bound", bus.count);
        end
        set_cmd(1'b1, 1'b1, 1'b1);
        step();
        set_cmd(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.count !== 8'd0 || bus.running !== 1'b0 || dut_vec() !== model_vec()) begin
            n_fail++;
            $display("FAIL allcmd_clear: got %h expected count 0 run 0", dut_vec());
        end
        do_start(1, 3);
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL allcmd_relatch: got %h expected %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_rate1_target0();
        int ticks;
        ticks = 0;
        do_clear();
        do_start(1, 0);
        for (int i = 0; i < 260; i++) begin
            step();
            if (bus.tick === 1'b1) ticks++;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL full_wrap i=%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
`ifndef COUNT_SEQ_WRAP_EN
        n_cmp++;
        if (ticks != 256 || bus.count !== 8'd0 || bus.done !== 1'b1 || bus.running !== 1'b0) begin
            n_fail++;
            $display("FAIL full_wrap_end: got ticks %0d count %0d done %b expected 256 0 1", ticks, bus.count, bus.done);
        end
`endif
    endtask

`ifdef COUNT_SEQ_WRAP_EN
    task automatic test_wrap();
        do_clear();
        do_start(1, 2);
        for (int k = 1; k <= 12; k++) begin
            step();
            n_cmp++;
            if (bus.count !== 8'(k % 3) || bus.done !== (k % 3 == 2) || bus.running !== 1'b1 || bus.tick !== 1'b1) begin
                n_fail++;
                $display("FAIL wrap_seq k=%0d: got %h expected count %0d", k, dut_vec(), k % 3);
            end
        end
    endtask
`endif

    task automatic test_back_to_back();
        do_clear();
        bus.rate   = '0;
        bus.target = 8'd2;
        set_cmd(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL back_to_back i=%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        set_cmd(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int r;
        do_clear();
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(99, 0);
            set_cmd(r >= 80, (r >= 70 && r < 76) || r == 99, r < 2);
            bus.rate   = DIV_WIDTH'($urandom_range(4, 0));
            bus.target = WIDTH'($urandom_range(12, 0));
            step();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++;
                $display("FAIL random i=%0d: got %h expected %h", i, dut_vec(), model_vec());
            end
        end
        set_cmd(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_oneshot_basic();
        test_pause();
        test_all_commands();
        test_rate1_target0();
`ifdef COUNT_SEQ_WRAP_EN
        test_wrap();
`endif
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
